// File: rtl/bp_stream_pump_in_if.sv
// Valid/yumi stream channel: one header (repeated per beat) plus one data beat.
// Header layout: {payload, addr[PaddrWidth], size[3], msg_type[4]}, size = log2(bytes).
interface bp_stream_pump_in_if #(
  parameter int unsigned HeaderWidth = 63,
  parameter int unsigned DataWidth   = 64
);
  logic [HeaderWidth-1:0] header;
  logic [DataWidth-1:0]   data;
  logic                   v;
  logic                   yumi;

  modport master (output header, data, v, input yumi);
  modport slave  (input header, data, v, output yumi);
endinterface

// File: rtl/bp_stream_pump_in.sv
// Inbound stream pump: presents bus beats to a local FSM one sub-block at a time, and on a
// client endpoint expands a multi-beat read command into per-sub-block read requests.
module bp_stream_pump_in #(
    parameter int unsigned PaddrWidth      = 40,
    parameter int unsigned PayloadWidth    = 16,
    parameter int unsigned StreamDataWidth = 64,
    parameter int unsigned BlockWidth      = 512,
    parameter bit          MasterP         = 1'b1,
    localparam int unsigned StreamWords    = BlockWidth / StreamDataWidth,
    localparam int unsigned CntW           = (StreamWords > 1) ? $clog2(StreamWords) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    bp_stream_pump_in_if.slave         mem_io,
    bp_stream_pump_in_if.master        fsm_io,
    output logic [CntW-1:0]            fsm_cnt_o,
    output logic                       fsm_new_o,
    output logic                       fsm_last_o,
    output logic                       done_o
);

    localparam int unsigned HeaderWidth = PayloadWidth + PaddrWidth + 7;
    localparam int unsigned BeatBytes   = StreamDataWidth / 8;
    localparam int unsigned OffW        = (BeatBytes > 1) ? $clog2(BeatBytes) : 1;
    localparam logic [2:0]  BeatSize    = 3'($clog2(BeatBytes));
    localparam logic [3:0]  MsgRd       = 4'd0;
    localparam logic [3:0]  MsgUcRd     = 4'd2;

    typedef enum logic [1:0] {StReady, StPass, StExpand} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        type_q, type_d;

    logic [HeaderWidth-1:0] hdr_in, hdr_out;
    logic [3:0]             msg_type;
    logic [2:0]             size_in;
    logic [PaddrWidth-1:0]  addr_in, addr_exp;
    logic [CntW-1:0]        first_cnt, last_cnt, cnt_cur;
    int unsigned            num_words;
    logic                   single, is_read, expand_mode, expand_sel;
    logic                   fsm_v, mem_yumi, last, consume;

    assign hdr_in   = mem_io.header;
    assign msg_type = hdr_in[3:0];
    assign size_in  = hdr_in[6:4];
    assign addr_in  = hdr_in[7 +: PaddrWidth];

    // Message geometry, all derived from the header presented on the bus
    always_comb begin
        if (32'(size_in) <= OffW) begin
            num_words = 1;
        end else begin
            num_words = 32'd1 << (32'(size_in) - OffW);
        end
        if (num_words > StreamWords) begin
            num_words = StreamWords;
        end
    end

    assign first_cnt   = addr_in[OffW +: CntW];
    assign last_cnt    = CntW'(32'(first_cnt) + num_words - 32'd1);
    assign single      = (num_words == 32'd1);
    assign is_read     = (msg_type == MsgRd) || (msg_type == MsgUcRd);
    assign expand_mode = !MasterP && is_read && !single;
    assign expand_sel  = (state_q == StExpand) || ((state_q == StReady) && expand_mode);

    assign cnt_cur = (state_q == StReady) ? first_cnt : cnt_q;
    assign last    = single || (cnt_cur == last_cnt);
    assign fsm_v   = mem_io.v && reset_n_i;
    assign consume = fsm_v && fsm_io.yumi;

    always_comb begin
        addr_exp                 = addr_in;
        addr_exp[OffW +: CntW]   = cnt_cur;
        hdr_out                  = hdr_in;
        mem_yumi                 = fsm_io.yumi && reset_n_i;
        fsm_io.data              = mem_io.data;
        if (expand_sel) begin
            // Bus header stays on the bus until the final sub-request is taken
            hdr_out[7 +: PaddrWidth] = addr_exp;
            hdr_out[6:4]             = BeatSize;
            fsm_io.data              = '0;
            mem_yumi                 = fsm_io.yumi && reset_n_i && last;
        end
    end

    assign fsm_io.header = hdr_out;
    assign fsm_io.v      = fsm_v;
    assign mem_io.yumi   = mem_yumi;
    assign fsm_cnt_o     = cnt_cur;
    assign fsm_new_o     = (state_q == StReady);
    assign fsm_last_o    = last;
    assign done_o        = consume && last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        unique case (state_q)
            StReady: begin
                if (consume) begin
                    type_d = msg_type;
                    if (!single) begin
                        cnt_d   = first_cnt + CntW'(1);
                        state_d = expand_mode ? StExpand : StPass;
                    end
                end
            end
            StPass, StExpand: begin
                if (consume) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (last) begin
                        state_d = StReady;
                    end
                end
            end
            default: state_d = StReady;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= StReady;
            cnt_q   <= '0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end

    yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fsm_io.yumi |-> fsm_v);

    pass_type_stable_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_q == StPass && mem_io.v) |-> (msg_type == type_q));

endmodule

// File: tb/tb_bp_stream_pump_in.sv
// Scoreboard bench: stimulus pushes expected FSM-side beats, a negedge monitor pops on consume.
module tb_bp_stream_pump_in;

    localparam int unsigned HW = 63;

    typedef struct packed {
        logic [2:0]  cnt;
        logic        nw;
        logic        last;
        logic        done;
        logic        myumi;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sel = 1'b0;  // 0: master DUT, 1: client DUT
    logic [HW-1:0] bus_hdr = '0;
    logic [63:0]   bus_data = '0;
    logic          bus_v = 1'b0;
    logic          yumi = 1'b0;

    int    n_checks = 0;
    int    n_pass = 0;
    beat_t exp_q[$];

    logic [2:0] m_cnt, c_cnt;
    logic       m_new, c_new, m_last, c_last, m_done, c_done;

    always #5 clk = ~clk;

    bp_stream_pump_in_if #(.HeaderWidth(HW), .DataWidth(64)) m_mem ();
    bp_stream_pump_in_if #(.HeaderWidth(HW), .DataWidth(64)) m_fsm ();
    bp_stream_pump_in_if #(.HeaderWidth(HW), .DataWidth(64)) c_mem ();
    bp_stream_pump_in_if #(.HeaderWidth(HW), .DataWidth(64)) c_fsm ();

    assign m_mem.header = bus_hdr;
    assign m_mem.data   = bus_data;
    assign m_mem.v      = bus_v && !sel;
    assign m_fsm.yumi   = yumi && !sel;
    assign c_mem.header = bus_hdr;
    assign c_mem.data   = bus_data;
    assign c_mem.v      = bus_v && sel;
    assign c_fsm.yumi   = yumi && sel;

    bp_stream_pump_in #(.MasterP(1'b1)) dut_m (
        .clk_i(clk), .reset_n_i(reset_n), .mem_io(m_mem), .fsm_io(m_fsm),
        .fsm_cnt_o(m_cnt), .fsm_new_o(m_new), .fsm_last_o(m_last), .done_o(m_done));

    bp_stream_pump_in #(.MasterP(1'b0)) dut_c (
        .clk_i(clk), .reset_n_i(reset_n), .mem_io(c_mem), .fsm_io(c_fsm),
        .fsm_cnt_o(c_cnt), .fsm_new_o(c_new), .fsm_last_o(c_last), .done_o(c_done));

    logic          obs_v, obs_yumi;
    logic [HW-1:0] obs_hdr;
    beat_t         obs;

    always_comb begin
        obs_v    = sel ? c_fsm.v : m_fsm.v;
        obs_yumi = sel ? c_fsm.yumi : m_fsm.yumi;
        obs_hdr  = sel ? c_fsm.header : m_fsm.header;
        obs.cnt   = sel ? c_cnt : m_cnt;
        obs.nw    = sel ? c_new : m_new;
        obs.last  = sel ? c_last : m_last;
        obs.done  = sel ? c_done : m_done;
        obs.myumi = sel ? c_mem.yumi : m_mem.yumi;
        obs.addr  = obs_hdr[7 +: 40];
        obs.size  = obs_hdr[6:4];
        obs.data  = sel ? c_fsm.data : m_fsm.data;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                             input logic [39:0] a);
        return {16'hA5A5, a, sz, t};
    endfunction

    function automatic logic [63:0] data_of(input logic [7:0] tag, input int b);
        return {tag, 48'h0, 8'(b)};
    endfunction

    task automatic push(input logic [2:0] cnt, input logic nw, input logic last,
                        input logic myumi, input logic [39:0] addr, input logic [2:0] size,
                        input logic [63:0] data);
        beat_t e;
        e.cnt = cnt; e.nw = nw; e.last = last; e.done = last; e.myumi = myumi;
        e.addr = addr; e.size = size; e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every consumed FSM beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (obs_v && obs_yumi) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'(obs), 128'(0));
            end else begin
                check("beat", 128'(obs), 128'(exp_q.pop_front()));
            end
        end
    end

    // Drive one message; n_sub FSM consumes per bus beat, optional toggle and stall
    task automatic send(input logic [HW-1:0] h, input logic [7:0] tag, input int n_bus,
                        input int n_sub, input bit toggle, input int stall_at,
                        input int stall_len, input logic [2:0] stall_cnt);
        int k = 0;
        for (int b = 0; b < n_bus; b++) begin
            bus_hdr = h; bus_data = data_of(tag, b); bus_v = 1'b1;
            for (int s = 0; s < n_sub; s++) begin
                if (toggle && k > 0) begin
                    yumi = 1'b0; @(posedge clk); #1;
                end
                if (k == stall_at) begin
                    yumi = 1'b0;
                    for (int j = 0; j < stall_len; j++) begin
                        @(negedge clk);
                        check("stall_hold", {obs_v, obs.myumi, obs.cnt, obs.data},
                              {1'b1, 1'b0, stall_cnt, data_of(tag, b)});
                        @(posedge clk); #1;
                    end
                end
                yumi = 1'b1; @(posedge clk); #1; k++;
            end
        end
        bus_v = 1'b0; yumi = 1'b0;
    endtask

    initial begin
        logic [39:0] exp_addr [8];
        logic [2:0]  exp_cnt  [8];
        exp_addr = '{40'h8030, 40'h8038, 40'h8000, 40'h8008, 40'h8010, 40'h8018, 40'h8020,
                     40'h8028};
        exp_cnt  = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

        // Reset gating with bus valid and FSM yumi both driven high
        bus_hdr = mk_hdr(4'd0, 3'd6, 40'h0); bus_v = 1'b1; yumi = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_master", {m_fsm.v, m_mem.yumi, m_done}, 3'b000);
        sel = 1'b1; #1;
        check("reset_client", {c_fsm.v, c_mem.yumi, c_done}, 3'b000);
        @(posedge clk); #1;
        bus_v = 1'b0; yumi = 1'b0; sel = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Master: 64B read response, 8 beats at full rate
        for (int i = 0; i < 8; i++)
            push(3'(i), i == 0, i == 7, 1'b1, 40'h4000, 3'd6, data_of(8'h11, i));
        send(mk_hdr(4'd0, 3'd6, 40'h4000), 8'h11, 8, 1, 1'b0, -1, 0, 3'd0);

        // Master: 8B uc_rd single beat, then back-to-back second single beat
        push(3'd7, 1'b1, 1'b1, 1'b1, 40'h1238, 3'd3, data_of(8'h22, 0));
        send(mk_hdr(4'd2, 3'd3, 40'h1238), 8'h22, 1, 1, 1'b0, -1, 0, 3'd0);
        push(3'd1, 1'b1, 1'b1, 1'b1, 40'h2008, 3'd3, data_of(8'h23, 0));
        send(mk_hdr(4'd2, 3'd3, 40'h2008), 8'h23, 1, 1, 1'b0, -1, 0, 3'd0);

        // Master: 8 beats with a 5-cycle FSM stall before beat 4
        for (int i = 0; i < 8; i++)
            push(3'(i), i == 0, i == 7, 1'b1, 40'h4000, 3'd6, data_of(8'h33, i));
        send(mk_hdr(4'd0, 3'd6, 40'h4000), 8'h33, 8, 1, 1'b0, 4, 5, 3'd4);

        // Master: reset after 3 of 8 beats; a fresh 16B message at offset 0x10 follows
        for (int i = 0; i < 3; i++)
            push(3'(i), i == 0, 1'b0, 1'b1, 40'h0, 3'd6, data_of(8'h44, i));
        send(mk_hdr(4'd0, 3'd6, 40'h0), 8'h44, 3, 1, 1'b0, -1, 0, 3'd0);
        bus_data = data_of(8'h44, 3); bus_v = 1'b1; reset_n = 1'b0;
        @(negedge clk);
        check("reset_mid_burst", {m_fsm.v, m_mem.yumi, m_done}, 3'b000);
        @(posedge clk); #1;
        reset_n = 1'b1; bus_v = 1'b0;
        @(posedge clk); #1;
        bus_hdr = mk_hdr(4'd0, 3'd4, 40'h10); bus_v = 1'b1;
        @(negedge clk);
        check("restart_first", {m_new, m_cnt}, {1'b1, 3'd2});
        push(3'd2, 1'b1, 1'b0, 1'b1, 40'h10, 3'd4, data_of(8'h55, 0));
        push(3'd3, 1'b0, 1'b1, 1'b1, 40'h10, 3'd4, data_of(8'h55, 1));
        @(posedge clk); #1;
        send(mk_hdr(4'd0, 3'd4, 40'h10), 8'h55, 2, 1, 1'b0, -1, 0, 3'd0);

        // Client: 64B read command expanded into 8 sub-block requests
        sel = 1'b1;
        for (int i = 0; i < 8; i++)
            push(exp_cnt[i], i == 0, i == 7, i == 7, exp_addr[i], 3'd3, 64'h0);
        send(mk_hdr(4'd0, 3'd6, 40'h8030), 8'h66, 1, 8, 1'b0, -1, 0, 3'd0);

        // Client: 32B write passes through, FSM yumi toggling
        for (int i = 0; i < 4; i++)
            push(3'(i), i == 0, i == 3, 1'b1, 40'h200, 3'd5, data_of(8'h77, i));
        send(mk_hdr(4'd1, 3'd5, 40'h200), 8'h77, 4, 1, 1'b1, -1, 0, 3'd0);

        // Client: single-beat read is not expanded
        push(3'd5, 1'b1, 1'b1, 1'b1, 40'h9028, 3'd3, data_of(8'h88, 0));
        send(mk_hdr(4'd0, 3'd3, 40'h9028), 8'h88, 1, 1, 1'b0, -1, 0, 3'd0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
